// File: rtl/br_upd_sched_pkg.sv
// br_pkg: types and constants shared by the branch-predictor update scheduler.
//   BR_PC_W  - width of the PC/target fields held in each queue entry
//   br_upd_t - one resolved-branch update as stored in the queue
package br_pkg;

  localparam int BR_PC_W = 64;

  typedef struct packed {
    logic [BR_PC_W-1:0] pc;
    logic [BR_PC_W-1:0] target;
    logic               is_cond;
    logic               taken;
  } br_upd_t;

endpackage

// File: rtl/br_upd_sched_if.sv
// br_upd_sched_if: signal bundle between the EX-stage branch units, the
// update scheduler and the predictor update port.
//   req0_*/req1_*  resolved-branch requests and their same-cycle accept
//   flush_i        squash queued and incoming updates
//   hold_i         predictor cannot take an update this cycle
//   upd_*          predictor update port (ex_is_br_i, ex_is_cond_i, ...)
//   count_o        queue occupancy
// Modports: master = branch units / predictor side, slave = scheduler.
interface br_upd_sched_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
);

  logic                     req0_valid_i;
  logic                     req0_is_cond_i;
  logic                     req0_taken_i;
  logic [PC_W-1:0]          req0_pc_i;
  logic [PC_W-1:0]          req0_target_i;
  logic                     req0_ready_o;

  logic                     req1_valid_i;
  logic                     req1_is_cond_i;
  logic                     req1_taken_i;
  logic [PC_W-1:0]          req1_pc_i;
  logic [PC_W-1:0]          req1_target_i;
  logic                     req1_ready_o;

  logic                     flush_i;
  logic                     hold_i;

  logic                     upd_valid_o;
  logic                     upd_is_cond_o;
  logic                     upd_taken_o;
  logic [PC_W-1:0]          upd_pc_o;
  logic [PC_W-1:0]          upd_target_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output req0_valid_i, req0_is_cond_i, req0_taken_i, req0_pc_i, req0_target_i,
    output req1_valid_i, req1_is_cond_i, req1_taken_i, req1_pc_i, req1_target_i,
    output flush_i, hold_i,
    input  req0_ready_o, req1_ready_o,
    input  upd_valid_o, upd_is_cond_o, upd_taken_o, upd_pc_o, upd_target_o,
    input  count_o
  );

  modport slave (
    input  req0_valid_i, req0_is_cond_i, req0_taken_i, req0_pc_i, req0_target_i,
    input  req1_valid_i, req1_is_cond_i, req1_taken_i, req1_pc_i, req1_target_i,
    input  flush_i, hold_i,
    output req0_ready_o, req1_ready_o,
    output upd_valid_o, upd_is_cond_o, upd_taken_o, upd_pc_o, upd_target_o,
    output count_o
  );

endinterface

// File: rtl/br_upd_sched_fifo.sv
// br_upd_fifo: 2-write / 1-read ring buffer of br_upd_t entries with occupancy.
//   clk, rst        clock, async active-low reset
//   flush           clears count and both pointers at the next edge
//   wr0_en/wr0_data first write, lands at tail
//   wr1_en/wr1_data second write, lands at tail+1 (only used together with wr0)
//   rd_en           pop the head entry
//   head_data       entry at the head (meaningful only when !empty)
//   count, empty    occupancy
module br_upd_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr0_en,
  input  br_upd_t                wr0_data,
  input  logic                   wr1_en,
  input  br_upd_t                wr1_data,
  input  logic                   rd_en,
  output br_upd_t                head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  br_upd_t         mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(wr0_en) + PW'(wr1_en);
      head  <= head + PW'(rd_en);
      count <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end
  end

  // Storage needs no reset: empty entries are never presented downstream.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (wr0_en) mem[tail] <= wr0_data;
      if (wr1_en) mem[tail + PW'(1)] <= wr1_data;
    end
  end

  assign head_data = mem[head];
  assign empty     = (count == '0);

endmodule

// File: rtl/br_upd_sched.sv
// br_upd_sched: buffers resolved-branch updates from two branch units and
// drains them one per cycle into the predictor's single update port.
//   clk  clock, rising edge
//   rst  async reset, active low
//   bus  br_upd_sched_if.slave: requests/accepts, flush, hold, upd_*, count
// Optional build macro BR_UPD_BYPASS_EN: when the queue is empty and the
// predictor is free, the preferred request goes straight to upd_* in the
// same cycle instead of being queued.
module br_upd_sched
  import br_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = BR_PC_W
) (
  input  logic           clk,
  input  logic           rst,
  br_upd_sched_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic          empty;
  logic          rr;
  logic          both;
  logic          grant0, grant1;
  logic          acc0, acc1;
  logic          byp0, byp1;
  logic          enq0, enq1;
  logic          wr0_en, wr1_en;
  logic          pop;
  br_upd_t       req0_e, req1_e;
  br_upd_t       wr0_d, wr1_d;
  br_upd_t       head_e, upd_e;

  always_comb begin
    req0_e.pc      = BR_PC_W'(bus.req0_pc_i);
    req0_e.target  = BR_PC_W'(bus.req0_target_i);
    req0_e.is_cond = bus.req0_is_cond_i;
    req0_e.taken   = bus.req0_taken_i;
    req1_e.pc      = BR_PC_W'(bus.req1_pc_i);
    req1_e.target  = BR_PC_W'(bus.req1_target_i);
    req1_e.is_cond = bus.req1_is_cond_i;
    req1_e.taken   = bus.req1_taken_i;
  end

  // Space is judged on the start-of-cycle count; a same-cycle pop does not
  // make room, which keeps the grant path off the hold/pop logic.
  always_comb begin
    free_slots = CW'(DEPTH) - count;
    both       = bus.req0_valid_i & bus.req1_valid_i;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (free_slots >= CW'(2)) begin
      grant0 = bus.req0_valid_i;
      grant1 = bus.req1_valid_i;
    end else if (free_slots == CW'(1)) begin
      if (both) begin
        grant0 = ~rr;
        grant1 = rr;
      end else begin
        grant0 = bus.req0_valid_i;
        grant1 = bus.req1_valid_i;
      end
    end
    acc0 = grant0 & ~bus.flush_i;
    acc1 = grant1 & ~bus.flush_i;
  end

  always_comb begin
    byp0 = 1'b0;
    byp1 = 1'b0;
`ifdef BR_UPD_BYPASS_EN
    if (empty && !bus.hold_i && !bus.flush_i) begin
      if (acc0 && (!acc1 || !rr)) byp0 = 1'b1;
      else if (acc1)              byp1 = 1'b1;
    end
`endif
  end

  // Pack accepted requests onto write port 0 first; when both are written the
  // rr-preferred one takes the lower slot so the predictor sees it first.
  always_comb begin
    enq0   = acc0 & ~byp0;
    enq1   = acc1 & ~byp1;
    wr0_en = 1'b0;
    wr1_en = 1'b0;
    wr0_d  = req0_e;
    wr1_d  = req1_e;
    if (enq0 && enq1) begin
      wr0_en = 1'b1;
      wr1_en = 1'b1;
      if (rr) begin
        wr0_d = req1_e;
        wr1_d = req0_e;
      end
    end else if (enq0) begin
      wr0_en = 1'b1;
      wr0_d  = req0_e;
    end else if (enq1) begin
      wr0_en = 1'b1;
      wr0_d  = req1_e;
    end
    pop = ~empty & ~bus.hold_i & ~bus.flush_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   rr <= 1'b0;
    else if (both && !bus.flush_i) rr <= ~rr;
  end

  br_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush_i),
    .wr0_en    (wr0_en),
    .wr0_data  (wr0_d),
    .wr1_en    (wr1_en),
    .wr1_data  (wr1_d),
    .rd_en     (pop),
    .head_data (head_e),
    .count     (count),
    .empty     (empty)
  );

  always_comb begin
    upd_e = '0;
    if (!empty)    upd_e = head_e;
    else if (byp0) upd_e = req0_e;
    else if (byp1) upd_e = req1_e;
  end

  assign bus.req0_ready_o  = acc0;
  assign bus.req1_ready_o  = acc1;
  assign bus.upd_valid_o   = pop | byp0 | byp1;
  assign bus.upd_is_cond_o = upd_e.is_cond;
  assign bus.upd_taken_o   = upd_e.taken;
  assign bus.upd_pc_o      = PC_W'(upd_e.pc);
  assign bus.upd_target_o  = PC_W'(upd_e.target);
  assign bus.count_o       = count;

endmodule

// File: tb/tb_br_upd_sched.sv
// Directed bench for br_upd_sched (DEPTH=4, PC_W=64). Inputs are driven just
// after the falling edge and outputs checked 1 time unit later.
module tb_br_upd_sched;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  br_upd_sched_if #(.DEPTH(4), .PC_W(64)) bus ();

  br_upd_sched #(.DEPTH(4), .PC_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [63:0] pc0,
                       input logic v1, input logic [63:0] pc1);
    bus.req0_valid_i   = v0;
    bus.req0_pc_i      = pc0;
    bus.req0_target_i  = pc0 + 64'h40;
    bus.req0_is_cond_i = v0;
    bus.req0_taken_i   = v0;
    bus.req1_valid_i   = v1;
    bus.req1_pc_i      = pc1;
    bus.req1_target_i  = pc1 + 64'h40;
    bus.req1_is_cond_i = 1'b0;
    bus.req1_taken_i   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.flush_i = 1'b0;
    bus.hold_i  = 1'b0;
    drive(0, 0, 0, 0);
    #2;
    check("rst_count", bus.count_o, 0);
    check("rst_upd_valid", bus.upd_valid_o, 0);
    check("rst_upd_pc", bus.upd_pc_o, 0);
    check("rst_upd_target", bus.upd_target_o, 0);
    check("rst_ready0", bus.req0_ready_o, 0);

    // single request, latency
    @(negedge clk); rst = 1'b1; drive(1, 64'h100, 0, 0); #1;
    check("t1_ready0", bus.req0_ready_o, 1);
    check("t1_ready1", bus.req1_ready_o, 0);
`ifdef BR_UPD_BYPASS_EN
    check("t1_byp_valid", bus.upd_valid_o, 1);
    check("t1_byp_pc", bus.upd_pc_o, 64'h100);
    @(negedge clk); drive(0, 0, 0, 0); #1;
    check("t1_byp_count", bus.count_o, 0);
`else
    check("t1_valid_same", bus.upd_valid_o, 0);
    @(negedge clk); drive(0, 0, 0, 0); #1;
    check("t1_valid", bus.upd_valid_o, 1);
    check("t1_pc", bus.upd_pc_o, 64'h100);
    check("t1_taken", bus.upd_taken_o, 1);
    check("t1_target", bus.upd_target_o, 64'h140);
    check("t1_count1", bus.count_o, 1);
`endif
    @(negedge clk); #1;
    check("t1_count0", bus.count_o, 0);
    check("t1_idle_valid", bus.upd_valid_o, 0);
    check("t1_idle_pc", bus.upd_pc_o, 0);

    // fill under hold; order A1,B1,B2,A2; rr ends at 1
    @(negedge clk); bus.hold_i = 1'b1; drive(1, 64'hA1, 1, 64'hB1); #1;
    check("t2_c1_r0", bus.req0_ready_o, 1);
    check("t2_c1_r1", bus.req1_ready_o, 1);
    @(negedge clk); drive(1, 64'hA2, 1, 64'hB2); #1;
    check("t2_c2_r0", bus.req0_ready_o, 1);
    check("t2_c2_r1", bus.req1_ready_o, 1);
    check("t2_c2_count", bus.count_o, 2);
    check("t2_c2_held_valid", bus.upd_valid_o, 0);
    check("t2_c2_held_pc", bus.upd_pc_o, 64'hA1);
    @(negedge clk); drive(1, 64'hA3, 1, 64'hB3); #1;
    check("t2_c3_r0", bus.req0_ready_o, 0);
    check("t2_c3_r1", bus.req1_ready_o, 0);
    check("t2_c3_count", bus.count_o, 4);
    @(negedge clk); bus.hold_i = 1'b0; drive(0, 0, 0, 0); #1;
    check("t2_d0_valid", bus.upd_valid_o, 1);
    check("t2_d0_pc", bus.upd_pc_o, 64'hA1);
    check("t2_d0_count", bus.count_o, 4);
    @(negedge clk); #1;
    check("t2_d1_pc", bus.upd_pc_o, 64'hB1);
    check("t2_d1_count", bus.count_o, 3);
    @(negedge clk); #1;
    check("t2_d2_pc", bus.upd_pc_o, 64'hB2);
    @(negedge clk); #1;
    check("t2_d3_pc", bus.upd_pc_o, 64'hA2);
    check("t2_d3_cond", bus.upd_is_cond_o, 1);
    @(negedge clk); #1;
    check("t2_empty_count", bus.count_o, 0);
    check("t2_empty_valid", bus.upd_valid_o, 0);

    // count=3 with rr=1, both valid -> only req1
    @(negedge clk); bus.hold_i = 1'b1; drive(1, 64'hC1, 0, 0);
    @(negedge clk); drive(1, 64'hC2, 0, 0);
    @(negedge clk); drive(1, 64'hC3, 0, 0);
    @(negedge clk); drive(1, 64'hD0, 1, 64'hD1); #1;
    check("t3_count3", bus.count_o, 3);
    check("t3_r0", bus.req0_ready_o, 0);
    check("t3_r1", bus.req1_ready_o, 1);
    @(negedge clk); drive(0, 0, 0, 0); #1;
    check("t3_count4", bus.count_o, 4);
    @(negedge clk); bus.hold_i = 1'b0; #1;
    check("t3_pop_c1", bus.upd_pc_o, 64'hC1);
    @(negedge clk); #1;
    check("t3_pop_c2", bus.upd_pc_o, 64'hC2);
    @(negedge clk); bus.hold_i = 1'b1; #1;
    check("t3_count2", bus.count_o, 2);
    check("t3_head_c3", bus.upd_pc_o, 64'hC3);

    // flush with both valid: nothing accepted, nothing popped, rr kept
    @(negedge clk); bus.hold_i = 1'b0; bus.flush_i = 1'b1; drive(1, 64'hE0, 1, 64'hE1); #1;
    check("fl_r0", bus.req0_ready_o, 0);
    check("fl_r1", bus.req1_ready_o, 0);
    check("fl_valid", bus.upd_valid_o, 0);
    @(negedge clk); bus.flush_i = 1'b0; drive(0, 0, 0, 0); #1;
    check("fl_count", bus.count_o, 0);
    check("fl_valid_after", bus.upd_valid_o, 0);
    check("fl_pc_after", bus.upd_pc_o, 0);

    // rr=0 after flush: F0,F1 then G1,G0; full+pop then grants resume
    @(negedge clk); bus.hold_i = 1'b1; drive(1, 64'hF0, 1, 64'hF1); #1;
    check("rr_c1_r0", bus.req0_ready_o, 1);
    check("rr_c1_r1", bus.req1_ready_o, 1);
    @(negedge clk); drive(1, 64'h60, 1, 64'h61);
    @(negedge clk); bus.hold_i = 1'b0; drive(1, 64'h70, 1, 64'h71); #1;
    check("full_count", bus.count_o, 4);
    check("full_r0", bus.req0_ready_o, 0);
    check("full_r1", bus.req1_ready_o, 0);
    check("full_pc", bus.upd_pc_o, 64'hF0);
    @(negedge clk); drive(1, 64'h80, 1, 64'h81); #1;
    check("resume_count", bus.count_o, 3);
    check("resume_r0", bus.req0_ready_o, 0);
    check("resume_r1", bus.req1_ready_o, 1);
    check("resume_pc", bus.upd_pc_o, 64'hF1);
    @(negedge clk); drive(0, 0, 0, 0); #1;
    check("pre_rst_count", bus.count_o, 3);
    check("pre_rst_valid", bus.upd_valid_o, 1);
    check("pre_rst_pc", bus.upd_pc_o, 64'h61);

    // asynchronous reset between edges
    #1; rst = 1'b0; #1;
    check("arst_count", bus.count_o, 0);
    check("arst_valid", bus.upd_valid_o, 0);
    check("arst_pc", bus.upd_pc_o, 0);
    @(negedge clk); rst = 1'b1;

    // empty queue, req1 alone
    @(negedge clk); drive(0, 0, 1, 64'h200); #1;
    check("e1_r1", bus.req1_ready_o, 1);
`ifdef BR_UPD_BYPASS_EN
    check("byp_valid", bus.upd_valid_o, 1);
    check("byp_pc", bus.upd_pc_o, 64'h200);
    @(negedge clk); drive(0, 0, 0, 0); #1;
    check("byp_count", bus.count_o, 0);
`else
    check("e1_valid_same", bus.upd_valid_o, 0);
    @(negedge clk); drive(0, 0, 0, 0); #1;
    check("e1_count", bus.count_o, 1);
    check("e1_pc", bus.upd_pc_o, 64'h200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_upd_sched.md
# br_upd_sched

Update scheduler for the branch predictor (direction predictor plus BTB). It accepts resolved-branch updates from two branch execution units and buffers them in an in-order queue. It drains them one per cycle into the predictor's single update port (`ex_is_br_i`/`ex_is_cond_i`/`ex_is_taken_i`/`ex_pc_i`/`ex_br_target_i`). It sits between the EX-stage branch units and `branch_pred`, and arbitrates fairly when the queue is nearly full.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `PC_W`, 64: PC/target width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `req0_valid_i` / `req1_valid_i`  in  1  requester has a resolved branch this cycle.
- `req0_is_cond_i` / `req1_is_cond_i`  in  1  branch is conditional.
- `req0_taken_i` / `req1_taken_i`  in  1  resolved direction.
- `req0_pc_i` / `req1_pc_i`  in  PC_W  branch PC.
- `req0_target_i` / `req1_target_i`  in  PC_W  resolved target.
- `req0_ready_o` / `req1_ready_o`  out  1  update accepted this cycle (combinational).
- `flush_i`  in  1  squash all queued and incoming updates.
- `hold_i`  in  1  predictor cannot accept an update this cycle.
- `upd_valid_o`  out  1  drives predictor `ex_is_br_i`.
- `upd_is_cond_o`, `upd_taken_o`  out  1  drive `ex_is_cond_i`, `ex_is_taken_i`.
- `upd_pc_o`, `upd_target_o`  out  PC_W  drive `ex_pc_i`, `ex_br_target_i`.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Free slots = `DEPTH - count`, using the start-of-cycle count. A same-cycle dequeue does not free space for enqueue.
- Grant rules:
  - Free ≥2: all valid requests are granted.
  - Free = 1 with both requesting: only the priority holder (round-robin pointer `rr`) is granted.
  - Free = 0: no grants.
- `reqN_ready_o` = `reqN_valid_i` AND granted AND NOT `flush_i`.
- Enqueue order when both are granted: the `rr`-preferred requester goes first (lower slot). This fixes the update order seen by the predictor history.
- `rr` toggles in every cycle where both requesters are valid and `flush_i`=0. `rr`=0 means req0 is preferred.
- Dequeue: `upd_valid_o` = queue non-empty AND NOT `hold_i` AND NOT `flush_i`. The head pops on every cycle where `upd_valid_o`=1.
- Payload outputs show the head entry whenever the queue is non-empty, and are 0 when it is empty.
- `count` next value = `count` + grants − pop. It never exceeds `DEPTH` and never underflows.
- Pointers wrap modulo `DEPTH`.
- `flush_i`=1: in the next cycle count=0 and head=tail=0. No enqueue and no dequeue occur in the flush cycle. `rr` is unchanged.

## Timing
- Reset: count=0, head=tail=0, `rr`=0. All outputs are 0, including the payload outputs.
- Reset mid-operation discards all entries immediately, because reset is asynchronous.
- Latency: a request accepted at edge N appears on `upd_*` in cycle N+1 if it is at the head.
- Throughput: 1 update per cycle out; 2 per cycle in.
- `hold_i` holds the head stable. Payload outputs do not change while held.
- Simultaneous full queue and pop: no grants that cycle. Grants resume the next cycle.

## Configuration
- `BR_UPD_BYPASS_EN` defined:
  - When the queue is empty, `hold_i`=0 and `flush_i`=0, the preferred valid request drives `upd_*` combinationally in the same cycle and is not written.
  - Any second request is enqueued.
  - Latency becomes 0 in this case.
- Undefined: no bypass; minimum latency is 1 cycle.

## Structure
- Package `br_pkg`:
  - typedef `br_upd_t` with fields {pc, target, is_cond, taken}.
  - Constant `BR_PC_W`=64.
- Sub-module `br_upd_fifo`: a 2-write/1-read ring buffer with count, parameterised by `DEPTH`.
- The top level holds grant/`rr` logic and the optional bypass.

## Test plan
- Reset release, req0 valid pc=0x100 taken=1 → ready0=1; cycle+1: `upd_valid_o`=1, `upd_pc_o`=0x100, `upd_taken_o`=1, count returns to 0.
- Both valid every cycle with `hold_i`=1 (DEPTH=4):
  - cycle 1: both granted;
  - cycle 2: both granted (count=4);
  - cycle 3: none granted.
  - Release hold → four updates drain in order req0,req1,req1,req0 per the `rr` history.
- Count=3, both valid, `rr`=1 → only ready1=1; count=4; `rr` toggles to 0.
- Count=2 with `flush_i`=1 and req0 valid → ready0=0, `upd_valid_o`=0; next cycle count=0, outputs 0.
- Assert `rst`=0 mid-cycle with count=3 → count_o=0 and `upd_valid_o`=0 immediately, before the next edge.
- With `BR_UPD_BYPASS_EN`: empty queue, req1 valid pc=0x200 → `upd_valid_o`=1 and `upd_pc_o`=0x200 in the same cycle; count stays 0.
